// File: rtl/voice_sequencer.sv
// voice_sequencer
//   Sweeps voice_index across every voice once per sample_tick (one voice per
//   clock), presents each voice's gated phase increment aligned to the
//   accumulator read latency, and tags the accumulator output stream with
//   {phase_valid, phase_voice} so the wavetable/mixer knows whose phase it is.
//
// Parameters
//   NUM_VOICES  voices per sweep (2..256)
//   DELTA_LAG   cycles from voice_index = k to delta_phase for voice k (>= 1)
//   PHASE_LAG   cycles from voice_index = k to output_phase for voice k
//               (>= DELTA_LAG)
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   sample_tick       starts a sweep (ignored and flagged while busy)
//   cfg_we/cfg_voice/cfg_delta/cfg_gate
//                     per-voice table write {gate, delta}
//   overrun_clr       clears the sticky overrun flag
//   voice_index       accumulator read index
//   delta_phase       accumulator increment (0 unless a gated voice is aligned)
//   phase_valid/phase_voice
//                     tag for the accumulator output of the current cycle
//   busy              sweep or drain in progress
//   frame_done        one-cycle pulse at end of frame
//   overrun           sticky: a sample_tick arrived while busy
module voice_sequencer #(
  parameter int NUM_VOICES = 128,
  parameter int DELTA_LAG  = 2,
  parameter int PHASE_LAG  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_voice,
  input  logic [31:0] cfg_delta,
  input  logic        cfg_gate,
  input  logic        overrun_clr,
  output logic [7:0]  voice_index,
  output logic [31:0] delta_phase,
  output logic        phase_valid,
  output logic [7:0]  phase_voice,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int AW = $clog2(NUM_VOICES);
  localparam int DW = $clog2(PHASE_LAG + 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t        state, state_next;
  logic [7:0]    count, count_next;
  logic [DW-1:0] drain, drain_next;
  logic          overrun_next;

  logic [NUM_VOICES-1:0] gate;
  logic [31:0]           delta_mem [NUM_VOICES];
  logic [31:0]           rd_delta;
  logic                  rd_live;
  logic                  wr_ok;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;

  logic [PHASE_LAG-1:0]  tag_valid;
  logic [7:0]            tag_voice [PHASE_LAG];

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      drain   <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      drain   <= drain_next;
      overrun <= overrun_next;
    end
  end

  // Next-state logic. count doubles as voice_index and is left untouched
  // outside SWEEP, so the index simply holds its last value there.
  always_comb begin
    state_next   = state;
    count_next   = count;
    drain_next   = drain;
    overrun_next = overrun;
    // A tick while busy sets the flag; set beats a coincident clear.
    if (sample_tick && busy) begin
      overrun_next = 1'b1;
    end else if (overrun_clr) begin
      overrun_next = 1'b0;
    end
    case (state)
      IDLE: begin
        if (sample_tick) begin
          state_next = SWEEP;
          count_next = '0;
        end
      end
      SWEEP: begin
        if (count == 8'(NUM_VOICES - 1)) begin
          state_next = DRAIN;
          drain_next = '0;
        end else begin
          count_next = count + 8'd1;
        end
      end
      DRAIN: begin
        if (drain == DW'(PHASE_LAG)) begin
          state_next = IDLE;
        end else begin
          drain_next = drain + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign frame_done  = (state == DRAIN) && (drain == DW'(PHASE_LAG));
  assign voice_index = count;

  // Out-of-range addresses must not alias onto a real voice.
  assign wr_ok   = cfg_we && ({1'b0, cfg_voice} < 9'(NUM_VOICES));
  assign wr_addr = cfg_voice[AW-1:0];
  assign rd_addr = count[AW-1:0];

  // Gate bits and the read-side enable are reset so that a reset silences
  // every voice immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate    <= '0;
      rd_live <= 1'b0;
    end else begin
      if (wr_ok) begin
        gate[wr_addr] <= cfg_gate;
      end
      rd_live <= (state == SWEEP) && gate[rd_addr];
    end
  end

  // Delta RAM: unreset, single-cycle registered read. The read samples the
  // old contents when a write hits the same entry (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      delta_mem[wr_addr] <= cfg_delta;
    end
    rd_delta <= delta_mem[rd_addr];
  end

  // The RAM read already supplies one cycle of lag; the remaining
  // DELTA_LAG-1 stages carry the masked increment so it is zero everywhere
  // except the aligned cycle of a gated-on voice.
  generate
    if (DELTA_LAG == 1) begin : g_delta_direct
      assign delta_phase = rd_live ? rd_delta : '0;
    end else begin : g_delta_pipe
      logic [31:0] pipe [DELTA_LAG-1];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DELTA_LAG - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= rd_live ? rd_delta : '0;
          for (int i = 1; i < DELTA_LAG - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign delta_phase = pipe[DELTA_LAG-2];
    end
  endgenerate

  // Tag pipeline: {valid, voice} follows voice_index by PHASE_LAG cycles.
  // Every swept voice is tagged, gated or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      for (int i = 0; i < PHASE_LAG; i++) tag_voice[i] <= '0;
    end else begin
      tag_valid[0] <= (state == SWEEP);
      tag_voice[0] <= count;
      for (int i = 1; i < PHASE_LAG; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_voice[i] <= tag_voice[i-1];
      end
    end
  end

  assign phase_valid = tag_valid[PHASE_LAG-1];
  assign phase_voice = tag_voice[PHASE_LAG-1];

endmodule

// File: tb/tb_voice_sequencer.sv
// tb_voice_sequencer
//   Self-checking bench for voice_sequencer. A timeline reference model
//   (cycles since sweep start, snapshot of the table taken when each voice
//   is read) predicts every output each cycle; table-driven vectors and
//   hand-written sequences add fixed expected values for the corner cases.
module tb_voice_sequencer;

  localparam int N = 128;
  localparam int D = 2;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_voice = '0;
  logic [31:0] cfg_delta = '0;
  logic        cfg_gate = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [7:0]  voice_index;
  logic [31:0] delta_phase;
  logic        phase_valid;
  logic [7:0]  phase_voice;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  voice_sequencer #(.NUM_VOICES(N), .DELTA_LAG(D), .PHASE_LAG(P)) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice), .cfg_delta(cfg_delta), .cfg_gate(cfg_gate),
    .overrun_clr(overrun_clr), .voice_index(voice_index),
    .delta_phase(delta_phase), .phase_valid(phase_valid),
    .phase_voice(phase_voice), .busy(busy), .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  bit          m_gate  [N];
  logic [31:0] m_delta [N];
  bit          r_gate  [N];
  logic [31:0] r_delta [N];
  bit          m_active = 0;
  int          m_rel = 0;
  int          m_held = 0;
  bit          m_ov = 0;

  // Observed increment per voice for the current sweep, and tag count.
  logic [31:0] obs [N];
  int          valid_seen = 0;

  typedef struct {
    logic [7:0]  voice;
    logic        gate;
    logic [31:0] delta;
    int          probe;
    logic [31:0] expect_inc;
  } vec_t;
  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs with the model, drive this cycle's
  // inputs, then advance the model at the active edge.
  task automatic applyStimulus(input logic t, input logic we, input logic [7:0] v,
                               input logic g, input logic [31:0] d,
                               input logic clr);
    int k;
    int kp;
    logic [31:0] exp_delta;
    logic        exp_valid;
    @(negedge clk);
    k  = m_rel - D;
    kp = m_rel - P;
    exp_delta = (m_active && k >= 0 && k < N && r_gate[k]) ? r_delta[k] : 32'h0;
    exp_valid = m_active && kp >= 0 && kp < N;
    checkOutput("busy", 32'(busy), 32'(m_active));
    checkOutput("voice_index", 32'(voice_index),
                (m_active && m_rel < N) ? 32'(m_rel) : 32'(m_held));
    checkOutput("delta_phase", delta_phase, exp_delta);
    checkOutput("phase_valid", 32'(phase_valid), 32'(exp_valid));
    if (exp_valid) checkOutput("phase_voice", 32'(phase_voice), 32'(kp));
    checkOutput("frame_done", 32'(frame_done), 32'(m_active && m_rel == N + P));
    checkOutput("overrun", 32'(overrun), 32'(m_ov));
    if (m_active && k >= 0 && k < N) obs[k] = delta_phase;
    if (phase_valid) valid_seen++;

    sample_tick = t;
    cfg_we      = we;
    cfg_voice   = v;
    cfg_gate    = g;
    cfg_delta   = d;
    overrun_clr = clr;
    @(posedge clk);

    if (m_active && m_rel < N) begin
      r_gate[m_rel]  = m_gate[m_rel];
      r_delta[m_rel] = m_delta[m_rel];
      m_held         = m_rel;
    end
    if (t && m_active) m_ov = 1;
    else if (clr) m_ov = 0;
    if (m_active) begin
      if (m_rel == N + P) m_active = 0;
      else m_rel++;
    end else if (t) begin
      m_active = 1;
      m_rel    = 0;
    end
    if (we && int'(v) < N) begin
      m_gate[v]  = g;
      m_delta[v] = d;
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
  endtask

  // Runs n cycles after an accepted tick (call r is cycle t1+r), with an
  // optional table write, extra tick and overrun clear at given offsets.
  task automatic runSweep(input int n, input int wr_rel, input logic [7:0] wv,
                          input logic wg, input logic [31:0] wd,
                          input int tick_rel, input int clr_rel);
    for (int r = 0; r < n; r++) begin
      applyStimulus(r == tick_rel, r == wr_rel, wv, wg, wd, r == clr_rel);
    end
  endtask

  task automatic startSweep();
    for (int i = 0; i < N; i++) obs[i] = 32'hDEAD_BEEF;
    valid_seen = 0;
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 32'h0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any edge.
  task automatic pulseReset();
    #2;
    reset       = 1'b1;
    sample_tick = 1'b0;
    cfg_we      = 1'b0;
    overrun_clr = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_delta_phase", delta_phase, 32'd0);
    checkOutput("rst_phase_valid", 32'(phase_valid), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_voice_index", 32'(voice_index), 32'd0);
    checkOutput("rst_phase_voice", 32'(phase_voice), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    m_active = 0;
    m_rel    = 0;
    m_held   = 0;
    m_ov     = 0;
    for (int i = 0; i < N; i++) m_gate[i] = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nonzero;

    vecs[0] = '{8'd5,   1'b1, 32'h0100_0000, 5,   32'h0100_0000};
    vecs[1] = '{8'd6,   1'b0, 32'hFFFF_FFFF, 6,   32'h0000_0000};
    vecs[2] = '{8'd200, 1'b1, 32'h1234_5678, 72,  32'h0000_0000};
    vecs[3] = '{8'd133, 1'b1, 32'h0000_DEAD, 5,   32'h0100_0000};
    vecs[4] = '{8'd127, 1'b1, 32'h7777_0001, 127, 32'h7777_0001};
    vecs[5] = '{8'd0,   1'b1, 32'h0000_0003, 0,   32'h0000_0003};
    vecs[6] = '{8'd255, 1'b0, 32'h0000_0001, 127, 32'h7777_0001};

    for (int i = 0; i < N; i++) begin
      m_gate[i]  = 0;
      m_delta[i] = '0;
      r_gate[i]  = 0;
      r_delta[i] = '0;
    end

    // Power-on reset values.
    @(negedge clk);
    checkOutput("por_busy", 32'(busy), 32'd0);
    checkOutput("por_delta_phase", delta_phase, 32'd0);
    checkOutput("por_phase_valid", 32'(phase_valid), 32'd0);
    checkOutput("por_voice_index", 32'(voice_index), 32'd0);
    checkOutput("por_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    idleCycle();

    // All gates off: full sweep, zero increments, 128 tags.
    startSweep();
    runSweep(N + P + 1, -1, 8'd0, 1'b0, 32'h0, -1, -1);
    nonzero = 0;
    for (int i = 0; i < N; i++) if (obs[i] != 32'h0) nonzero++;
    checkOutput("allgates_off_nonzero", 32'(nonzero), 32'd0);
    checkOutput("allgates_off_tags", 32'(valid_seen), 32'(N));
    idleCycle();

    // Table vectors, including ignored out-of-range addresses.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, vecs[i].voice, vecs[i].gate, vecs[i].delta, 1'b0);
    end
    idleCycle();
    startSweep();
    runSweep(N + P + 1, -1, 8'd0, 1'b0, 32'h0, -1, -1);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("vec%0d_voice%0d", i, vecs[i].probe),
                  obs[vecs[i].probe], vecs[i].expect_inc);
    end
    idleCycle();

    // Write to voice 9 in the cycle it is read: old value this sweep.
    startSweep();
    runSweep(N + P + 1, 9, 8'd9, 1'b1, 32'h0000_0010, -1, -1);
    checkOutput("collide_same_sweep", obs[9], 32'h0);

    // Next sweep sees it; a tick at t1+50 sets overrun, cleared at t1+60.
    startSweep();
    runSweep(N + P + 1, -1, 8'd0, 1'b0, 32'h0, 50, 60);
    checkOutput("collide_next_sweep", obs[9], 32'h0000_0010);
    checkOutput("overrun_timing_voice5", obs[5], 32'h0100_0000);
    checkOutput("overrun_cleared", 32'(overrun), 32'd0);

    // Tick in the cycle right after frame_done is accepted.
    startSweep();
    #1;
    checkOutput("tick_after_done_busy", 32'(busy), 32'd1);

    // Reset at t1+60 abandons the sweep and clears the gates.
    runSweep(60, -1, 8'd0, 1'b0, 32'h0, -1, -1);
    pulseReset();
    idleCycle();
    startSweep();
    runSweep(N + P + 1, -1, 8'd0, 1'b0, 32'h0, -1, -1);
    checkOutput("post_reset_voice5", obs[5], 32'h0);
    checkOutput("post_reset_voice127", obs[127], 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      logic        t;
      logic        we;
      logic [7:0]  v;
      logic        clr;
      t   = ($urandom_range(0, 29) == 0);
      we  = ($urandom_range(0, 2) == 0);
      v   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255))
                                        : 8'($urandom_range(0, 127));
      clr = ($urandom_range(0, 19) == 0);
      applyStimulus(t, we, v, 1'($urandom_range(0, 1)), $urandom, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
